elastic_pipeline: RTL

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

---
 rtl/elastic_pipeline.sv | 106 ++++++++++
 1 files changed

// File: rtl/elastic_pipeline.sv
// Elastic valid/ready pipeline of LEVEL register stages with bubble collapsing.
// Ports: clk/rst (sync, active-high), flush, s_* upstream, m_* downstream, count = held beats.
module elastic_pipeline #(
  parameter int DATA_WIDTH = 8,
  parameter int LEVEL      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(LEVEL+1)-1:0]   count
);

  localparam int CW = $clog2(LEVEL+1);

  logic [LEVEL-1:0]      v_q;
  logic [LEVEL-1:0]      v_d;
  logic [LEVEL-1:0]      en;
  logic [LEVEL-1:0]      in_v;
  logic [DATA_WIDTH-1:0] d_q [LEVEL];
  logic [DATA_WIDTH-1:0] d_d [LEVEL];

  // A stage may advance when any stage at or after it is empty,
  // or the sink is taking the last beat.
  function automatic logic [LEVEL-1:0] calc_en(
    input logic [LEVEL-1:0] v,
    input logic             rdy
  );
    logic [LEVEL-1:0] e;
    logic             acc;
    acc = rdy;
    e   = '0;
    for (int i = LEVEL-1; i >= 0; i--) begin
      acc  = acc | ~v[i];
      e[i] = acc;
    end
    return e;
  endfunction

  function automatic logic [CW-1:0] popcnt(
    input logic [LEVEL-1:0] v
  );
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < LEVEL; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  assign en      = calc_en(v_q, m_ready);
  assign s_ready = en[0] & ~flush & ~rst;
  assign m_valid = v_q[LEVEL-1];
  assign m_data  = d_q[LEVEL-1];
  assign count   = popcnt(v_q);

  always_comb begin
    in_v    = '0;
    in_v[0] = s_valid & s_ready;
    for (int i = 1; i < LEVEL; i++) begin
      in_v[i] = v_q[i-1];
    end
  end

  // Data only moves with a valid beat so empty slots keep old payload.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < LEVEL; i++) begin
      d_d[i] = d_q[i];
    end
    if (en[0]) begin
      v_d[0] = in_v[0];
      if (in_v[0]) begin
        d_d[0] = s_data;
      end
    end
    for (int i = 1; i < LEVEL; i++) begin
      if (en[i]) begin
        v_d[i] = in_v[i];
        if (in_v[i]) begin
          d_d[i] = d_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < LEVEL; i++) begin
        d_q[i] <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule
